// File: rtl/spmv_result_collector_if.sv
// spmv_result_collector_if: result stream from the collector to its downstream consumer
interface spmv_result_collector_if #(
  parameter int ROW_W = 11
);
  logic             valid;
  logic             ready;
  logic [ROW_W-1:0] row;
  logic [63:0]      data1;
  logic [63:0]      data2;
  logic             last;
  modport master (output valid, row, data1, data2, last, input ready);
  modport slave  (input valid, row, data1, data2, last, output ready);
endinterface

// File: rtl/spmv_result_collector.sv
// spmv_result_collector: gathers per-row SpMV results into a FIFO and streams them downstream
module spmv_result_collector #(
  parameter int NUM_ROWS = 1120,
  parameter int DEPTH    = 16,
  parameter int ROW_W    = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic                     in_zeros,
  input  logic [63:0]              in_data1,
  input  logic [63:0]              in_data2,
  spmv_result_collector_if.master  out,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = ROW_W + 128;
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;
  state_t          state_q, state_d;
  logic [1:0]      sync_q;
  logic            rst_sync_n;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]     level_q, level_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic            ovf_q, ovf_d;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [EW-1:0]   head;
  logic            begin_pass, attempt, pop, full, push, last_row;
  // Reset asserts immediately but releases only after two clock edges
  always_ff @(posedge clk or negedge rst)
    if (!rst) sync_q <= 2'b00;
    else      sync_q <= {sync_q[0], 1'b1};
  assign rst_sync_n = sync_q[1];
  // Next-state, pointer, occupancy and row-counter logic
  always_comb begin
    begin_pass = start && (state_q == IDLE || state_q == DONE);
    attempt    = state_q == COLLECT && (in_valid || in_zeros);
    pop        = out.valid && out.ready;
    full       = level_q == (PW+1)'(DEPTH);
    push       = attempt && (!full || pop);
    last_row   = row_q == ROW_W'(NUM_ROWS - 1);
    wr_ptr_d   = begin_pass ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d   = begin_pass ? '0 : rd_ptr_q + PW'(pop);
    level_d    = begin_pass ? '0 : level_q + (PW+1)'(push) - (PW+1)'(pop);
    row_d      = begin_pass ? '0 : row_q + ROW_W'(attempt);
    ovf_d      = begin_pass ? 1'b0 : ovf_q || (attempt && !push);
    state_d    = state_q;
    if (begin_pass) state_d = COLLECT;
    else if (attempt && last_row) state_d = DRAIN;
    else if (state_q == DRAIN && level_d == '0) state_d = DONE;
  end
  // Control state registers
  always_ff @(posedge clk or negedge rst_sync_n)
    if (!rst_sync_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      row_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      row_q    <= row_d;
      ovf_q    <= ovf_d;
    end
  // Storage write; a zero row stores zero data, in_valid takes priority over in_zeros
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= {row_q, in_valid ? in_data1 : 64'd0, in_valid ? in_data2 : 64'd0};
  assign head      = mem_q[rd_ptr_q];
  assign out.valid = level_q != '0;
  assign out.row   = out.valid ? head[EW-1 -: ROW_W] : '0;
  assign out.data1 = out.valid ? head[127:64] : '0;
  assign out.data2 = out.valid ? head[63:0] : '0;
  assign out.last  = out.valid && head[EW-1 -: ROW_W] == ROW_W'(NUM_ROWS - 1);
  assign level     = level_q;
  assign busy      = state_q == COLLECT || state_q == DRAIN;
  assign done      = state_q == DONE;
  assign overflow  = ovf_q;
endmodule
